// File: rtl/mem_instr_seq_if.sv
// Bundle of the instruction handshake and the nibble-memory port for mem_instr_seq.
// The environment (instruction source plus memory) takes the master side; the sequencer takes the slave side.
interface mem_instr_seq_if #(
    parameter int unsigned ROW_W  = 3,
    parameter int unsigned DATA_W = 4
) ();
    logic              in_valid;
    logic              in_ready;
    logic              in_op;
    logic [ROW_W-1:0]  in_row;
    logic              in_sector;
    logic [ROW_W-1:0]  mem_row_addr;
    logic              mem_sector;
    logic              mem_read_write;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        output in_valid, in_op, in_row, in_sector, mem_data_out,
        input  in_ready, mem_row_addr, mem_sector, mem_read_write, mem_data_in
    );

    modport slave (
        input  in_valid, in_op, in_row, in_sector, mem_data_out,
        output in_ready, mem_row_addr, mem_sector, mem_read_write, mem_data_in
    );
endinterface

// File: rtl/mem_instr_seq.sv
// Load/store sequencer in front of the 8x8 nibble memory: buffers instructions in a FIFO
// and owns accumulator r0, absorbing the memory's one-cycle registered read latency.
module mem_instr_seq #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ROW_W      = 3,
    parameter int unsigned DATA_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_instr_seq_if.slave    bus,
    output logic [DATA_W-1:0] r0,
    output logic              load_done,
    output logic              busy
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic             op;
        logic [ROW_W-1:0] row;
        logic             sector;
    } instr_t;

    typedef enum logic [1:0] {StIdle, StLd, StCap, StSt} state_e;

    instr_t            fifo_q [FIFO_DEPTH];
    instr_t            fifo_d [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              sector_q, sector_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] r0_q, r0_d;
    logic              load_done_q, load_done_d;

    logic   in_ready;
    logic   push;
    logic   pop;
    instr_t head;
    instr_t incoming;

    // Ready depends only on registered occupancy, so a pop never lets a push through early.
    assign in_ready = (count_q != CntW'(FIFO_DEPTH));
    assign push     = bus.in_valid && in_ready;
    assign head     = fifo_q[rd_ptr_q];
    assign incoming = '{op: bus.in_op, row: bus.in_row, sector: bus.in_sector};

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = incoming;
            wr_ptr_d         = PtrW'(wr_ptr_q + 1'b1);
        end
        if (pop) begin
            rd_ptr_d = PtrW'(rd_ptr_q + 1'b1);
        end
        case ({push, pop})
            2'b10:   count_d = CntW'(count_q + 1'b1);
            2'b01:   count_d = CntW'(count_q - 1'b1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        sector_d    = sector_q;
        rw_d        = rw_q;
        din_d       = din_q;
        r0_d        = r0_q;
        load_done_d = 1'b0;
        pop         = 1'b0;
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    row_d    = head.row;
                    sector_d = head.sector;
                    if (head.op) begin
                        rw_d    = 1'b1;
                        din_d   = '0;
                        state_d = StLd;
                    end else begin
                        // Store data is r0 as it stands at issue, which already includes a prior load.
                        rw_d    = 1'b0;
                        din_d   = r0_q;
                        state_d = StSt;
                    end
                end
            end
            StLd: begin
                state_d = StCap;
            end
            StCap: begin
                r0_d        = bus.mem_data_out;
                load_done_d = 1'b1;
                state_d     = StIdle;
            end
            StSt: begin
                rw_d    = 1'b1;
                din_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= StIdle;
            row_q       <= '0;
            sector_q    <= 1'b0;
            rw_q        <= 1'b1;
            din_q       <= '0;
            r0_q        <= '0;
            load_done_q <= 1'b0;
        end else begin
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            row_q       <= row_d;
            sector_q    <= sector_d;
            rw_q        <= rw_d;
            din_q       <= din_d;
            r0_q        <= r0_d;
            load_done_q <= load_done_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.mem_row_addr   = row_q;
    assign bus.mem_sector     = sector_q;
    assign bus.mem_read_write = rw_q;
    assign bus.mem_data_in    = din_q;
    assign r0                 = r0_q;
    assign load_done          = load_done_q;
    assign busy               = (state_q != StIdle) || (count_q != '0);
endmodule

// File: tb/tb_mem_instr_seq.sv
// Directed bench for mem_instr_seq with a behavioural 8x8 nibble memory (OR-on-write,
// one-cycle registered read) preloaded with rows 1, 2 and 7.
module tb_mem_instr_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] r0;
    logic       load_done;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_instr_seq_if #(.ROW_W(3), .DATA_W(4)) ifc ();

    mem_instr_seq #(
        .FIFO_DEPTH(4),
        .ROW_W     (3),
        .DATA_W    (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (ifc),
        .r0       (r0),
        .load_done(load_done),
        .busy     (busy)
    );

    logic [7:0] mem [8] = '{8'h00, 8'hCB, 8'h39, 8'h00, 8'h00, 8'h00, 8'h00, 8'h8F};
    logic [3:0] mem_dout_q = 4'h0;

    always @(posedge clk) begin
        if (!ifc.mem_read_write) begin
            if (ifc.mem_sector) mem[ifc.mem_row_addr][3:0] <= mem[ifc.mem_row_addr][3:0] | ifc.mem_data_in;
            else                mem[ifc.mem_row_addr][7:4] <= mem[ifc.mem_row_addr][7:4] | ifc.mem_data_in;
        end else begin
            mem_dout_q <= ifc.mem_sector ? mem[ifc.mem_row_addr][3:0] : mem[ifc.mem_row_addr][7:4];
        end
    end
    assign ifc.mem_data_out = mem_dout_q;

    // Observed stores as {row, sector, data} and observed load results.
    logic [7:0] st_log [$];
    logic [3:0] ld_log [$];
    int         n_bad_din = 0;
    logic       busy_at_done = 1'b1;

    always @(negedge clk) begin
        if (rst_n && !ifc.mem_read_write)
            st_log.push_back({ifc.mem_row_addr, ifc.mem_sector, ifc.mem_data_in});
        if (ifc.mem_read_write && ifc.mem_data_in != 4'h0)
            n_bad_din++;
        if (load_done) begin
            ld_log.push_back(r0);
            busy_at_done = busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic op, input logic [2:0] row, input logic sec);
        ifc.in_valid  = 1'b1;
        ifc.in_op     = op;
        ifc.in_row    = row;
        ifc.in_sector = sec;
        for (int i = 0; i < 50; i++) begin
            if (ifc.in_ready) break;
            @(negedge clk);
        end
        if (!ifc.in_ready) check("send_ready_timeout", ifc.in_ready, 1);
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("idle_reached", busy, 0);
        @(negedge clk);
    endtask

    int sb, lb;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.in_valid  = 1'b0;
        ifc.in_op     = 1'b0;
        ifc.in_row    = 3'd0;
        ifc.in_sector = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rw", ifc.mem_read_write, 1);
        check("rst_din", ifc.mem_data_in, 0);
        check("rst_row", ifc.mem_row_addr, 0);
        check("rst_sector", ifc.mem_sector, 0);
        check("rst_r0", r0, 0);
        check("rst_load_done", load_done, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", ifc.in_ready, 1);

        // 1: plain load
        sb = st_log.size(); lb = ld_log.size();
        send(1'b1, 3'd1, 1'b1);
        wait_idle();
        check("t1_no_store", st_log.size() - sb, 0);
        check("t1_one_done", ld_log.size() - lb, 1);
        check("t1_ld_val", ld_log[lb], 4'b1011);
        check("t1_r0", r0, 4'b1011);

        // 2: store then load same nibble sees OR
        sb = st_log.size(); lb = ld_log.size();
        send(1'b0, 3'd2, 1'b1);
        send(1'b1, 3'd2, 1'b1);
        wait_idle();
        check("t2_one_store", st_log.size() - sb, 1);
        check("t2_store", st_log[sb], {3'd2, 1'b1, 4'b1011});
        check("t2_ld_val", ld_log[lb], 4'b1011);
        check("t2_r0", r0, 4'b1011);

        // 3: upper nibble, busy low on the cycle after CAP
        sb = st_log.size(); lb = ld_log.size();
        send(1'b0, 3'd7, 1'b0);
        send(1'b1, 3'd7, 1'b0);
        wait_idle();
        check("t3_store", st_log[sb], {3'd7, 1'b0, 4'b1011});
        check("t3_ld_val", ld_log[lb], 4'b1011);
        check("t3_busy_after_cap", busy_at_done, 0);

        // 4: six back-to-back instructions into a depth-4 FIFO
        sb = st_log.size(); lb = ld_log.size();
        send(1'b1, 3'd1, 1'b0);
        send(1'b0, 3'd3, 1'b1);
        send(1'b1, 3'd3, 1'b1);
        send(1'b1, 3'd2, 1'b0);
        send(1'b0, 3'd4, 1'b0);
        send(1'b1, 3'd4, 1'b0);
        check("t4_full", ifc.in_ready, 0);
        ifc.in_valid  = 1'b1;
        ifc.in_op     = 1'b0;
        ifc.in_row    = 3'd6;
        ifc.in_sector = 1'b1;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        wait_idle();
        check("t4_n_loads", ld_log.size() - lb, 4);
        check("t4_n_stores", st_log.size() - sb, 2);
        check("t4_ld0", ld_log[lb], 4'b1100);
        check("t4_ld1", ld_log[lb + 1], 4'b1100);
        check("t4_ld2", ld_log[lb + 2], 4'b0011);
        check("t4_ld3", ld_log[lb + 3], 4'b0011);
        check("t4_st0", st_log[sb], {3'd3, 1'b1, 4'b1100});
        check("t4_st1", st_log[sb + 1], {3'd4, 1'b0, 4'b0011});

        // 5: store right after load carries the freshly loaded r0
        sb = st_log.size(); lb = ld_log.size();
        send(1'b1, 3'd1, 1'b1);
        send(1'b0, 3'd0, 1'b0);
        wait_idle();
        check("t5_ld_val", ld_log[lb], 4'b1011);
        check("t5_store", st_log[sb], {3'd0, 1'b0, 4'b1011});
        check("din_zero_outside_st", n_bad_din, 0);

        // 6: reset in the ST cycle
        send(1'b0, 3'd5, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (!ifc.mem_read_write) break;
            @(negedge clk);
        end
        check("t6_reached_st", ifc.mem_read_write, 0);
        rst_n = 1'b0;
        #1;
        check("t6_rw_async", ifc.mem_read_write, 1);
        check("t6_din_async", ifc.mem_data_in, 0);
        check("t6_r0_async", r0, 0);
        check("t6_busy_async", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_in_ready", ifc.in_ready, 1);
        check("t6_busy", busy, 0);
        check("t6_r0", r0, 0);
        check("t6_load_done", load_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
